// File: rtl/monitor_pkg.sv
// monitor_pkg: shared types for the temperature delta monitor.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
// Contents: trend state enum, BCD digit typedef, controller state enum, digit clamp.
package monitor_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_STEADY  = 2'd1,
    TR_RISING  = 2'd2,
    TR_FALLING = 2'd3
  } trend_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_FIN   = 2'd3
  } ctrl_state_e;

  // Non-decimal nibbles (10..15) are treated as the largest legal digit.
  function automatic bcd_digit_t clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? bcd_digit_t'(4'd9) : bcd_digit_t'(d);
  endfunction

endpackage

// File: rtl/bcd_sub_digit.sv
// bcd_sub_digit: one-digit BCD subtract, diff = a - b - borrow_in (mod 10).
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: a_dig/b_dig operand digits (0..9), borrow_in, diff_dig result digit, borrow_out.
module bcd_sub_digit
  import monitor_pkg::*;
(
  input  bcd_digit_t a_dig,
  input  bcd_digit_t b_dig,
  input  logic       borrow_in,
  output bcd_digit_t diff_dig,
  output logic       borrow_out
);

  logic [4:0] raw;

  always_comb begin
    raw        = {1'b0, a_dig} - {1'b0, b_dig} - {4'b0000, borrow_in};
    // Negative raw difference: wrap back into 0..9 by adding ten.
    borrow_out = raw[4];
    diff_dig   = raw[4] ? bcd_digit_t'(raw[3:0] + 4'd10) : bcd_digit_t'(raw[3:0]);
  end

endmodule

// File: rtl/monitor_mc.sv
// monitor_mc: multi-channel signed-BCD temperature delta monitor with per-channel trend FSM.
// Latency: NUM_DIGITS+2 cycles accept-to-delta_valid (setup, one digit per cycle LSD first, output).
// Backpressure: one sample in flight; sample_ready low from accept until delta_valid (one cycle for discards).
// Optional feature macro: MONITOR_ALARM_EN (per-channel |delta| >= ALARM_DELTA alarm, two-result release).
// Ports: clk, rst (async active-low), en, mode, sample_valid/ready/ch/bcd/sign in,
//        delta_valid/ch/bcd/sign, trend, alarm out.
module monitor_mc
  import monitor_pkg::*;
#(
  parameter  int NUM_CH      = 4,
  parameter  int NUM_DIGITS  = 3,
  parameter  int ALARM_DELTA = 10,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MAG_W       = 4 * NUM_DIGITS,
  localparam int RES_W       = 4 * (NUM_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic [MAG_W-1:0]  sample_bcd,
  input  logic              sample_sign,
  output logic              delta_valid,
  output logic [CH_W-1:0]   delta_ch,
  output logic [RES_W-1:0]  delta_bcd,
  output logic              delta_sign,
  output logic [1:0]        trend,
  output logic [NUM_CH-1:0] alarm
);

  localparam int               CNT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIGITS - 1);

  ctrl_state_e       state_q, state_d;
  logic              mode_q, mode_d;
  logic [MAG_W-1:0]  smp_mag_q, smp_mag_d;
  logic              smp_sign_q, smp_sign_d;
  logic [CH_W-1:0]   smp_ch_q, smp_ch_d;

  logic [MAG_W-1:0]  prev_mag_q [NUM_CH];
  logic [MAG_W-1:0]  prev_mag_d [NUM_CH];
  logic [MAG_W-1:0]  base_mag_q [NUM_CH];
  logic [MAG_W-1:0]  base_mag_d [NUM_CH];
  trend_e            trend_arr_q [NUM_CH];
  trend_e            trend_arr_d [NUM_CH];
  logic [NUM_CH-1:0] prev_sign_q, prev_sign_d;
  logic [NUM_CH-1:0] base_sign_q, base_sign_d;
  logic [NUM_CH-1:0] hist_vld_q, hist_vld_d;

  logic [MAG_W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic              add_q, add_d, borrow_q, borrow_d;
  logic              res_sign_q, res_sign_d, res_zero_q, res_zero_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              delta_valid_q, delta_valid_d;
  logic [CH_W-1:0]   delta_ch_q, delta_ch_d;
  logic [RES_W-1:0]  delta_bcd_q, delta_bcd_d;
  logic              delta_sign_q, delta_sign_d;
  trend_e            trend_q, trend_d;

  logic              accept, ch_ok;
  logic [CH_W-1:0]   ch_idx;
  logic [MAG_W-1:0]  smp_clamped, ref_mag;
  logic              ref_sign;
  logic [MAG_W+3:0]  res_cat;
  logic [RES_W-1:0]  res_full;
  trend_e            new_trend;
  bcd_digit_t        sub_b, sub_d;
  logic              sub_bout;

  assign sample_ready = rst & en & (state_q == ST_IDLE);
  assign accept       = sample_valid & sample_ready;
  assign ch_ok        = ({1'b0, smp_ch_q} < (CH_W+1)'(NUM_CH));
  assign ch_idx       = ch_ok ? smp_ch_q : '0;

  always_comb begin
    smp_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      smp_clamped[4*i +: 4] = clamp_digit(sample_bcd[4*i +: 4]);
    end
  end

  // Reference for the pending sample; a channel without history references
  // itself so the first result falls out of the datapath as +0.
  always_comb begin
    ref_mag  = smp_mag_q;
    ref_sign = smp_sign_q;
    if (hist_vld_q[ch_idx]) begin
      if (mode_q) begin
        ref_mag  = base_mag_q[ch_idx];
        ref_sign = base_sign_q[ch_idx];
      end else begin
        ref_mag  = prev_mag_q[ch_idx];
        ref_sign = prev_sign_q[ch_idx];
      end
    end
  end

  // Magnitude addition reuses the subtractor: a+b+c == a-(9-b)-(1-c)+10,
  // so the subtrahend is nine's-complemented and borrow means "no carry".
  assign sub_b = add_q ? bcd_digit_t'(4'd9 - opb_q[3:0]) : bcd_digit_t'(opb_q[3:0]);

  bcd_sub_digit u_sub (
    .a_dig     (opa_q[3:0]),
    .b_dig     (sub_b),
    .borrow_in (borrow_q),
    .diff_dig  (sub_d),
    .borrow_out(sub_bout)
  );

  assign res_cat   = {sub_d, res_q} >> 4;
  assign res_full  = {(add_q ? {3'b000, ~borrow_q} : 4'd0), res_q};
  assign new_trend = res_zero_q ? TR_STEADY : (res_sign_q ? TR_FALLING : TR_RISING);

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    smp_mag_d     = smp_mag_q;
    smp_sign_d    = smp_sign_q;
    smp_ch_d      = smp_ch_q;
    prev_mag_d    = prev_mag_q;
    base_mag_d    = base_mag_q;
    trend_arr_d   = trend_arr_q;
    prev_sign_d   = prev_sign_q;
    base_sign_d   = base_sign_q;
    hist_vld_d    = hist_vld_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    res_d         = res_q;
    add_d         = add_q;
    borrow_d      = borrow_q;
    res_sign_d    = res_sign_q;
    res_zero_d    = res_zero_q;
    cnt_d         = cnt_q;
    delta_valid_d = 1'b0;
    delta_ch_d    = delta_ch_q;
    delta_bcd_d   = delta_bcd_q;
    delta_sign_d  = delta_sign_q;
    trend_d       = trend_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          smp_mag_d  = smp_clamped;
          smp_sign_d = sample_sign & (smp_clamped != '0);
          smp_ch_d   = sample_ch;
          mode_d     = mode;
          // A mode switch restarts every channel's history and trend.
          if (mode != mode_q) begin
            hist_vld_d = '0;
            for (int i = 0; i < NUM_CH; i++) trend_arr_d[i] = TR_IDLE;
          end
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (!ch_ok) begin
          state_d = ST_IDLE;
        end else begin
          // Order operands so the serial pass never ends with a borrow.
          if (smp_sign_q != ref_sign) begin
            opa_d      = smp_mag_q;
            opb_d      = ref_mag;
            add_d      = 1'b1;
            borrow_d   = 1'b1;
            res_zero_d = 1'b0;
            res_sign_d = smp_sign_q;
          end else if (smp_mag_q >= ref_mag) begin
            opa_d      = smp_mag_q;
            opb_d      = ref_mag;
            add_d      = 1'b0;
            borrow_d   = 1'b0;
            res_zero_d = (smp_mag_q == ref_mag);
            res_sign_d = smp_sign_q & ~res_zero_d;
          end else begin
            opa_d      = ref_mag;
            opb_d      = smp_mag_q;
            add_d      = 1'b0;
            borrow_d   = 1'b0;
            res_zero_d = 1'b0;
            res_sign_d = ~smp_sign_q;
          end
          res_d                = '0;
          cnt_d                = '0;
          prev_mag_d[ch_idx]   = smp_mag_q;
          prev_sign_d[ch_idx]  = smp_sign_q;
          if (!hist_vld_q[ch_idx]) begin
            base_mag_d[ch_idx]  = smp_mag_q;
            base_sign_d[ch_idx] = smp_sign_q;
            hist_vld_d[ch_idx]  = 1'b1;
          end
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        opa_d    = opa_q >> 4;
        opb_d    = opb_q >> 4;
        res_d    = res_cat[MAG_W-1:0];
        borrow_d = sub_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) state_d = ST_FIN;
      end

      ST_FIN: begin
        delta_valid_d       = 1'b1;
        delta_ch_d          = smp_ch_q;
        delta_bcd_d         = res_full;
        delta_sign_d        = res_sign_q;
        trend_d             = new_trend;
        trend_arr_d[ch_idx] = new_trend;
        state_d             = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      smp_mag_q     <= '0;
      smp_sign_q    <= 1'b0;
      smp_ch_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        prev_mag_q[i]  <= '0;
        base_mag_q[i]  <= '0;
        trend_arr_q[i] <= TR_IDLE;
      end
      prev_sign_q   <= '0;
      base_sign_q   <= '0;
      hist_vld_q    <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      res_q         <= '0;
      add_q         <= 1'b0;
      borrow_q      <= 1'b0;
      res_sign_q    <= 1'b0;
      res_zero_q    <= 1'b0;
      cnt_q         <= '0;
      delta_valid_q <= 1'b0;
      delta_ch_q    <= '0;
      delta_bcd_q   <= '0;
      delta_sign_q  <= 1'b0;
      trend_q       <= TR_IDLE;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      smp_mag_q     <= smp_mag_d;
      smp_sign_q    <= smp_sign_d;
      smp_ch_q      <= smp_ch_d;
      prev_mag_q    <= prev_mag_d;
      base_mag_q    <= base_mag_d;
      trend_arr_q   <= trend_arr_d;
      prev_sign_q   <= prev_sign_d;
      base_sign_q   <= base_sign_d;
      hist_vld_q    <= hist_vld_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      res_q         <= res_d;
      add_q         <= add_d;
      borrow_q      <= borrow_d;
      res_sign_q    <= res_sign_d;
      res_zero_q    <= res_zero_d;
      cnt_q         <= cnt_d;
      delta_valid_q <= delta_valid_d;
      delta_ch_q    <= delta_ch_d;
      delta_bcd_q   <= delta_bcd_d;
      delta_sign_q  <= delta_sign_d;
      trend_q       <= trend_d;
    end
  end

  assign delta_valid = delta_valid_q;
  assign delta_ch    = delta_ch_q;
  assign delta_bcd   = delta_bcd_q;
  assign delta_sign  = delta_sign_q;
  assign trend       = trend_q;

`ifdef MONITOR_ALARM_EN
  function automatic logic [RES_W-1:0] int_to_bcd(input int v);
    logic [RES_W-1:0] r;
    int               t;
    r = '0;
    t = v;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Packed BCD orders like the number it encodes, so a plain compare works.
  localparam logic [RES_W-1:0] ALARM_BCD = int_to_bcd(ALARM_DELTA);

  logic [NUM_CH-1:0] alarm_q, alarm_d;
  logic [NUM_CH-1:0] below_q, below_d;

  always_comb begin
    alarm_d = alarm_q;
    below_d = below_q;
    if (state_q == ST_FIN) begin
      if (res_full >= ALARM_BCD) begin
        alarm_d[ch_idx] = 1'b1;
        below_d[ch_idx] = 1'b0;
      end else if (alarm_q[ch_idx]) begin
        // Release needs a second consecutive quiet result on this channel.
        if (below_q[ch_idx]) begin
          alarm_d[ch_idx] = 1'b0;
          below_d[ch_idx] = 1'b0;
        end else begin
          below_d[ch_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_q <= '0;
      below_q <= '0;
    end else begin
      alarm_q <= alarm_d;
      below_q <= below_d;
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_monitor_mc.sv
// tb_monitor_mc: directed plus random stimulus against an integer-arithmetic channel model.
// Latency: checks accept-to-delta_valid of NUM_DIGITS+2 cycles on every result.
// Backpressure: waits on sample_ready before each offer, bounded.
module tb_monitor_mc;

  localparam int NCH = 6;
  localparam int ND  = 3;
  localparam int ALD = 10;
  localparam int CHW = 3;
  localparam int MW  = 4 * ND;
  localparam int RW  = 4 * (ND + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           mode;
  logic           sample_valid;
  logic           sample_ready;
  logic [CHW-1:0] sample_ch;
  logic [MW-1:0]  sample_bcd;
  logic           sample_sign;
  logic           delta_valid;
  logic [CHW-1:0] delta_ch;
  logic [RW-1:0]  delta_bcd;
  logic           delta_sign;
  logic [1:0]     trend;
  logic [NCH-1:0] alarm;

  always #5 clk = ~clk;

  monitor_mc #(.NUM_CH(NCH), .NUM_DIGITS(ND), .ALARM_DELTA(ALD)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_ch   (sample_ch),
    .sample_bcd  (sample_bcd),
    .sample_sign (sample_sign),
    .delta_valid (delta_valid),
    .delta_ch    (delta_ch),
    .delta_bcd   (delta_bcd),
    .delta_sign  (delta_sign),
    .trend       (trend),
    .alarm       (alarm)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: signed integers per channel.
  int m_prev [NCH];
  int m_base [NCH];
  bit m_vld  [NCH];
  int m_trend[NCH];
  bit m_alarm[NCH];
  int m_below[NCH];
  bit m_mode;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_prev[i] = 0; m_base[i] = 0; m_vld[i] = 0;
      m_trend[i] = 0; m_alarm[i] = 0; m_below[i] = 0;
    end
    m_mode = 0;
  endtask

  function automatic int bcd_val(input logic [MW-1:0] b);
    int v, d;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [RW-1:0] to_bcd(input int v);
    logic [RW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int i = 0; i < ND + 1; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_alarm();
    logic [NCH-1:0] a;
    for (int i = 0; i < NCH; i++) a[i] = m_alarm[i];
    return a;
  endfunction

  task automatic do_sample(input int ch, input logic [MW-1:0] bcd, input logic sgn,
                           input logic md, input bit drop_en);
    int            n, s, r, d, ad, lat;
    bit            seen, early;
    logic [RW-1:0] eb;
    @(negedge clk);
    n = 0;
    while (sample_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", sample_ready, 1);
    sample_ch    = ch[CHW-1:0];
    sample_bcd   = bcd;
    sample_sign  = sgn;
    mode         = md;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    if (drop_en) en = 1'b0;
    chk("ready_drop", sample_ready, 0);

    if (md != m_mode) begin
      for (int i = 0; i < NCH; i++) begin m_vld[i] = 0; m_trend[i] = 0; end
      m_mode = md;
    end

    if (ch >= NCH) begin
      @(posedge clk);
      #1;
      chk("disc_ready", sample_ready, 1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (delta_valid) seen = 1;
        @(posedge clk);
        #1;
      end
      chk("disc_no_dv", seen, 0);
      return;
    end

    s = bcd_val(bcd);
    if (sgn) s = -s;
    if (!m_vld[ch]) begin
      m_vld[ch] = 1; m_base[ch] = s; m_prev[ch] = s; r = s;
    end else begin
      r = md ? m_base[ch] : m_prev[ch];
      m_prev[ch] = s;
    end
    d  = s - r;
    ad = (d < 0) ? -d : d;
    m_trend[ch] = (d > 0) ? 2 : ((d < 0) ? 3 : 1);
`ifdef MONITOR_ALARM_EN
    if (ad >= ALD) begin
      m_alarm[ch] = 1; m_below[ch] = 0;
    end else if (m_alarm[ch]) begin
      m_below[ch]++;
      if (m_below[ch] == 2) begin m_alarm[ch] = 0; m_below[ch] = 0; end
    end
`endif
    eb = to_bcd(ad);

    lat = 0; seen = 0; early = 0;
    while (!seen && lat < 20) begin
      if (sample_ready) early = 1;
      @(posedge clk);
      #1;
      lat++;
      if (delta_valid === 1'b1) seen = 1;
    end
    chk("ready_busy", early, 0);
    chk("latency", lat, ND + 2);
    chk("delta_bcd", delta_bcd, eb);
    chk("delta_sign", delta_sign, (d < 0));
    chk("delta_ch", delta_ch, ch);
    chk("trend", trend, m_trend[ch]);
    chk("alarm", alarm, exp_alarm());
    if (drop_en) chk("ready_en_low", sample_ready, 0);
    @(posedge clk);
    #1;
    chk("dv_pulse", delta_valid, 0);
    chk("hold_bcd", delta_bcd, eb);
    en = 1'b1;
  endtask

  initial begin
    logic [MW-1:0] rb;
    int            rch;
    logic          rmd;
    bit            rdrop, seen;

    rst = 1'b0; en = 1'b1; mode = 1'b0; sample_valid = 1'b0;
    sample_ch = '0; sample_bcd = '0; sample_sign = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", sample_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_dv", delta_valid, 0);
    chk("rst_bcd", delta_bcd, 0);
    chk("rst_sign", delta_sign, 0);
    chk("rst_ch", delta_ch, 0);
    chk("rst_trend", trend, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_ready", sample_ready, 1);

    do_sample(0, 12'h025, 0, 0, 0);
    do_sample(0, 12'h031, 0, 0, 0);
    do_sample(1, 12'h005, 0, 0, 0);
    do_sample(1, 12'h007, 1, 0, 0);
    do_sample(1, 12'h999, 1, 0, 0);
    do_sample(1, 12'h999, 0, 0, 0);
    do_sample(2, 12'h100, 0, 1, 0);
    do_sample(2, 12'h090, 0, 1, 0);
    do_sample(2, 12'h100, 0, 1, 0);
    do_sample(2, 12'h055, 0, 0, 0);
    do_sample(0, 12'h090, 0, 0, 0);
    do_sample(0, 12'h0C5, 0, 0, 0);
    do_sample(4, 12'h000, 0, 0, 0);
    do_sample(4, 12'h000, 1, 0, 0);
    do_sample(6, 12'h123, 0, 0, 0);
    do_sample(7, 12'h321, 1, 0, 0);
    do_sample(1, 12'h050, 1, 0, 1);
    do_sample(3, 12'h000, 0, 0, 0);
    do_sample(3, 12'h012, 0, 0, 0);
    do_sample(3, 12'h015, 0, 0, 0);
    do_sample(3, 12'h016, 0, 0, 0);

    // Reset during an operation.
    @(negedge clk);
    sample_ch = '0; sample_bcd = 12'h123; sample_sign = 1'b0; mode = m_mode;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_dv", delta_valid, 0);
    chk("mid_rst_bcd", delta_bcd, 0);
    chk("mid_rst_sign", delta_sign, 0);
    chk("mid_rst_ch", delta_ch, 0);
    chk("mid_rst_trend", trend, 0);
    chk("mid_rst_alarm", alarm, 0);
    chk("mid_rst_ready", sample_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_ready", sample_ready, 1);
    model_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (delta_valid) seen = 1;
    end
    chk("mid_rst_no_dv", seen, 0);

    for (int k = 0; k < 80; k++) begin
      rch = $urandom_range(0, 7);
      for (int i = 0; i < ND; i++) rb[4*i +: 4] = 4'($urandom_range(0, 11));
      rmd   = m_mode;
      rdrop = 0;
      if (rch < NCH && $urandom_range(0, 9) == 0) rmd = ~m_mode;
      if (rch < NCH && $urandom_range(0, 5) == 0) rdrop = 1;
      do_sample(rch, rb, 1'($urandom_range(0, 1)), rmd, rdrop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
